// File: rtl/ioblock_cfg_ctrl.sv
// Serial configuration controller for a bank of IO blocks.
// Hunts the serial stream for a sync word, shifts in 3 bits per IO
// (TSMUX[1], TSMUX[0], DORREG), checks even parity, and then commits
// the whole frame to the IO bank in a single cycle.
module ioblock_cfg_ctrl #(
   parameter int          NUM_IO    = 4,
   parameter logic [7:0]  SYNC_WORD = 8'hA5
) (
   input  logic                  IOCLK,
   input  logic                  RSTN,
   input  logic                  CFG_VALID,
   input  logic                  CFG_DATA,
   output logic                  CFG_READY,
   input  logic                  CFG_ABORT,
   output logic [2*NUM_IO-1:0]   TSMUX_OUT,
   output logic [NUM_IO-1:0]     DORREG_OUT,
   output logic                  CFG_BUSY,
   output logic                  CFG_DONE,
   output logic                  CFG_ERR
);

   localparam int PAYLOAD_BITS = 3 * NUM_IO;
   localparam int CNT_W        = $clog2(PAYLOAD_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAYLOAD_BITS - 1);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      LOAD   = 2'd1,
      PARITY = 2'd2,
      COMMIT = 2'd3
   } state_t;

   state_t                    state;
   state_t                    state_next;
   logic                      accept;
   logic [7:0]                sync_reg;
   logic [7:0]                sync_shifted;
   logic                      sync_hit;
   logic [CNT_W-1:0]          bit_count;
   logic [PAYLOAD_BITS-1:0]   shadow;
   logic                      parity_acc;
   logic                      parity_ok;
   logic                      load_shift;
   logic [2*NUM_IO-1:0]       shadow_tsmux;
   logic [NUM_IO-1:0]         shadow_dorreg;

   assign accept       = CFG_VALID & CFG_READY;
   assign sync_shifted = {sync_reg[6:0], CFG_DATA};
   assign sync_hit     = (sync_shifted == SYNC_WORD);
   assign parity_ok    = (CFG_DATA == parity_acc);
   assign load_shift   = (state == LOAD) && accept && !CFG_ABORT;

   // State register; reset lands in HUNT.
   always_ff @(posedge IOCLK or negedge RSTN) begin
      if (!RSTN) begin
         state <= HUNT;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: abort beats any bit arriving in the same cycle,
   // except in COMMIT which always completes.
   always_comb begin
      state_next = state;
      case (state)
         HUNT: begin
            if (!CFG_ABORT && accept && sync_hit) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            if (CFG_ABORT) begin
               state_next = HUNT;
            end else if (accept && (bit_count == LAST_BIT)) begin
               state_next = PARITY;
            end
         end
         PARITY: begin
            if (CFG_ABORT) begin
               state_next = HUNT;
            end else if (accept) begin
               state_next = parity_ok ? COMMIT : HUNT;
            end
         end
         COMMIT: begin
            state_next = HUNT;
         end
         default: begin
            state_next = HUNT;
         end
      endcase
   end

   // Handshake and status outputs decoded from the current state.
   always_comb begin
      CFG_READY = 1'b1;
      CFG_BUSY  = 1'b0;
      case (state)
         HUNT:    CFG_BUSY = 1'b0;
         LOAD:    CFG_BUSY = 1'b1;
         PARITY:  CFG_BUSY = 1'b1;
         COMMIT: begin
            CFG_BUSY  = 1'b1;
            CFG_READY = 1'b0;
         end
         default: CFG_BUSY = 1'b0;
      endcase
   end

   // Sync shift register; held at zero outside HUNT so frame bits can never
   // combine with older bits into a false sync.
   always_ff @(posedge IOCLK or negedge RSTN) begin
      if (!RSTN) begin
         sync_reg <= 8'd0;
      end else if (state != HUNT) begin
         sync_reg <= 8'd0;
      end else if (CFG_ABORT) begin
         sync_reg <= 8'd0;
      end else if (accept) begin
         sync_reg <= sync_hit ? 8'd0 : sync_shifted;
      end
   end

   // Payload bit counter; it reaches PAYLOAD_BITS on the last bit and is
   // cleared once the FSM leaves LOAD, so it never wraps.
   always_ff @(posedge IOCLK or negedge RSTN) begin
      if (!RSTN) begin
         bit_count <= '0;
      end else if (load_shift) begin
         bit_count <= bit_count + 1'b1;
      end else if (state != LOAD) begin
         bit_count <= '0;
      end
   end

   // Shadow payload and running parity. Bits enter at the top and shift
   // down, so after the full payload bit j sits at shadow[j].
   always_ff @(posedge IOCLK or negedge RSTN) begin
      if (!RSTN) begin
         shadow     <= '0;
         parity_acc <= 1'b0;
      end else if (load_shift) begin
         shadow     <= {CFG_DATA, shadow[PAYLOAD_BITS-1:1]};
         parity_acc <= parity_acc ^ CFG_DATA;
      end else if ((state == HUNT) || (CFG_ABORT && (state != COMMIT))) begin
         shadow     <= '0;
         parity_acc <= 1'b0;
      end
   end

   // Unpack the shadow into per-IO fields: bit 3i -> TSMUX[1], 3i+1 -> TSMUX[0],
   // 3i+2 -> DORREG.
   always_comb begin
      shadow_tsmux  = '0;
      shadow_dorreg = '0;
      for (int i = 0; i < NUM_IO; i++) begin
         shadow_tsmux[2*i+1] = shadow[3*i];
         shadow_tsmux[2*i]   = shadow[3*i+1];
         shadow_dorreg[i]    = shadow[3*i+2];
      end
   end

   // Committed IO settings change only on the edge leaving COMMIT.
   always_ff @(posedge IOCLK or negedge RSTN) begin
      if (!RSTN) begin
         TSMUX_OUT  <= '0;
         DORREG_OUT <= '0;
      end else if (state == COMMIT) begin
         TSMUX_OUT  <= shadow_tsmux;
         DORREG_OUT <= shadow_dorreg;
      end
   end

   // One-cycle completion pulses for a committed or rejected frame.
   always_ff @(posedge IOCLK or negedge RSTN) begin
      if (!RSTN) begin
         CFG_DONE <= 1'b0;
         CFG_ERR  <= 1'b0;
      end else begin
         CFG_DONE <= (state == COMMIT);
         CFG_ERR  <= (state == PARITY) && accept && !CFG_ABORT && !parity_ok;
      end
   end

endmodule

// File: tb/tb_ioblock_cfg_ctrl.sv
// Self-checking bench for ioblock_cfg_ctrl with two IO blocks.
module tb_ioblock_cfg_ctrl;

   localparam int NIO = 2;

   logic             IOCLK;
   logic             RSTN;
   logic             CFG_VALID;
   logic             CFG_DATA;
   logic             CFG_READY;
   logic             CFG_ABORT;
   logic [2*NIO-1:0] TSMUX_OUT;
   logic [NIO-1:0]   DORREG_OUT;
   logic             CFG_BUSY;
   logic             CFG_DONE;
   logic             CFG_ERR;

   int vectors    = 0;
   int miscompares = 0;
   int doneSeen   = 0;
   int errSeen    = 0;

   logic [7:0] syncWord = 8'hA5;
   logic [3:0] modelTs  = 4'b0000;
   logic [1:0] modelDor = 2'b00;

   typedef struct {
      logic [5:0] payload;
      logic       parity;
      int         gap;
      int         abortAfter;
      bit         abortInCommit;
      logic [3:0] expTs;
      logic [1:0] expDor;
      bit         expDone;
      bit         expErr;
   } frame_vec_t;

   frame_vec_t vecs[10];

   ioblock_cfg_ctrl #(
      .NUM_IO    (NIO),
      .SYNC_WORD (8'hA5)
   ) dut (
      .IOCLK      (IOCLK),
      .RSTN       (RSTN),
      .CFG_VALID  (CFG_VALID),
      .CFG_DATA   (CFG_DATA),
      .CFG_READY  (CFG_READY),
      .CFG_ABORT  (CFG_ABORT),
      .TSMUX_OUT  (TSMUX_OUT),
      .DORREG_OUT (DORREG_OUT),
      .CFG_BUSY   (CFG_BUSY),
      .CFG_DONE   (CFG_DONE),
      .CFG_ERR    (CFG_ERR)
   );

   // Free-running clock.
   initial begin
      IOCLK = 1'b0;
      forever #5 IOCLK = ~IOCLK;
   end

   // Count completion pulses once per cycle, away from the active edge.
   always @(negedge IOCLK) begin
      if (RSTN) begin
         if (CFG_DONE) doneSeen++;
         if (CFG_ERR)  errSeen++;
      end
   end

   task automatic checkOutput(input string tag, input string name,
                              input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s/%s: got %0h, expected %0h", tag, name, actual, expected);
      end
   endtask

   // Present one cycle of inputs; returns just after the rising edge.
   task automatic applyStimulus(input logic v, input logic d, input logic a);
      @(negedge IOCLK);
      CFG_VALID = v;
      CFG_DATA  = d;
      CFG_ABORT = a;
      @(posedge IOCLK);
      #1;
   endtask

   // Expected IO settings straight from the bit-to-field mapping.
   function automatic void modelIo(input logic [5:0] p,
                                   output logic [3:0] ts, output logic [1:0] dor);
      ts  = '0;
      dor = '0;
      for (int io = 0; io < NIO; io++) begin
         ts[2*io+1] = p[3*io];
         ts[2*io]   = p[3*io+1];
         dor[io]    = p[3*io+2];
      end
   endfunction

   function automatic logic evenParity(input logic [5:0] p);
      int ones = 0;
      for (int j = 0; j < 6; j++) ones += int'(p[j]);
      return logic'(ones % 2);
   endfunction

   // Send one frame (optionally without the sync word) and check timing and result.
   task automatic runFrame(input string tag, input bit skipSync,
                           input logic [5:0] p, input logic par, input int gap,
                           input int abortAfter, input bit abortInCommit,
                           input logic [3:0] expTs, input logic [1:0] expDor,
                           input bit expDone, input bit expErr);
      int doneBefore = doneSeen;
      int errBefore  = errSeen;
      bit aborted    = 1'b0;
      if (!skipSync) begin
         for (int b = 7; b >= 0; b--) applyStimulus(1'b1, syncWord[b], 1'b0);
      end
      for (int j = 0; j < 6; j++) begin
         if (j == abortAfter) begin
            aborted = 1'b1;
            break;
         end
         applyStimulus(1'b1, p[j], 1'b0);
         for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 1'b0);
      end
      if (aborted) begin
         applyStimulus(1'b1, 1'b1, 1'b1);
         checkOutput(tag, "busy_after_abort", 32'(CFG_BUSY), 32'd0);
      end else begin
         applyStimulus(1'b1, par, 1'b0);
         if (expDone) begin
            checkOutput(tag, "ready_in_commit", 32'(CFG_READY), 32'd0);
            checkOutput(tag, "busy_in_commit", 32'(CFG_BUSY), 32'd1);
            checkOutput(tag, "done_early", 32'(CFG_DONE), 32'd0);
         end
         if (expErr) begin
            checkOutput(tag, "err_pulse", 32'(CFG_ERR), 32'd1);
            checkOutput(tag, "busy_after_err", 32'(CFG_BUSY), 32'd0);
         end
         applyStimulus(1'b0, 1'b0, abortInCommit);
         if (expDone) begin
            checkOutput(tag, "done_pulse", 32'(CFG_DONE), 32'd1);
            checkOutput(tag, "ready_after_commit", 32'(CFG_READY), 32'd1);
            checkOutput(tag, "tsmux_at_done", 32'(TSMUX_OUT), 32'(expTs));
         end
         if (expErr) begin
            checkOutput(tag, "err_width", 32'(CFG_ERR), 32'd0);
         end
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput(tag, "tsmux", 32'(TSMUX_OUT), 32'(expTs));
      checkOutput(tag, "dorreg", 32'(DORREG_OUT), 32'(expDor));
      checkOutput(tag, "done_count", 32'(doneSeen - doneBefore), 32'(expDone));
      checkOutput(tag, "err_count", 32'(errSeen - errBefore), 32'(expErr));
   endtask

   initial begin
      logic [1:0] hunt [9];
      logic [5:0] p;
      logic       par;
      bit         bad;
      int         gap;
      int         abortAfter;
      bit         abortInCommit;
      logic [3:0] ts;
      logic [1:0] dor;

      //                payload   par gap abort  cAbort expTs    expDor done err
      vecs[0] = '{6'b011110, 1'b0, 0, 99, 1'b0, 4'b1101, 2'b01, 1'b1, 1'b0};
      vecs[1] = '{6'b011110, 1'b1, 0, 99, 1'b0, 4'b1101, 2'b01, 1'b0, 1'b1};
      vecs[2] = '{6'b110001, 1'b1, 3, 99, 1'b0, 4'b0110, 2'b10, 1'b1, 1'b0};
      vecs[3] = '{6'b011110, 1'b0, 0, 3,  1'b0, 4'b0110, 2'b10, 1'b0, 1'b0};
      vecs[4] = '{6'b011110, 1'b0, 0, 99, 1'b1, 4'b1101, 2'b01, 1'b1, 1'b0};
      vecs[5] = '{6'b111111, 1'b0, 1, 99, 1'b0, 4'b1111, 2'b11, 1'b1, 1'b0};
      vecs[6] = '{6'b111111, 1'b1, 0, 99, 1'b0, 4'b1111, 2'b11, 1'b0, 1'b1};
      vecs[7] = '{6'b000000, 1'b0, 0, 99, 1'b0, 4'b0000, 2'b00, 1'b1, 1'b0};
      vecs[8] = '{6'b110001, 1'b1, 0, 99, 1'b0, 4'b0110, 2'b10, 1'b1, 1'b0};
      vecs[9] = '{6'b000000, 1'b0, 0, 0,  1'b0, 4'b0110, 2'b10, 1'b0, 1'b0};

      RSTN      = 1'b0;
      CFG_VALID = 1'b0;
      CFG_DATA  = 1'b0;
      CFG_ABORT = 1'b0;
      repeat (3) @(posedge IOCLK);
      #1;
      checkOutput("reset", "tsmux", 32'(TSMUX_OUT), 32'd0);
      checkOutput("reset", "dorreg", 32'(DORREG_OUT), 32'd0);
      checkOutput("reset", "ready", 32'(CFG_READY), 32'd1);
      checkOutput("reset", "busy", 32'(CFG_BUSY), 32'd0);
      checkOutput("reset", "done", 32'(CFG_DONE), 32'd0);
      checkOutput("reset", "err", 32'(CFG_ERR), 32'd0);
      @(negedge IOCLK);
      RSTN = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("idle", "busy", 32'(CFG_BUSY), 32'd0);

      for (int k = 0; k < 10; k++) begin
         runFrame($sformatf("vec%0d", k), 1'b0, vecs[k].payload, vecs[k].parity,
                  vecs[k].gap, vecs[k].abortAfter, vecs[k].abortInCommit,
                  vecs[k].expTs, vecs[k].expDor, vecs[k].expDone, vecs[k].expErr);
      end

      // Sync hunting: the sync word only appears at the ninth bit.
      hunt = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int b = 0; b < 8; b++) applyStimulus(1'b1, hunt[b], 1'b0);
      checkOutput("hunt", "busy_before_sync", 32'(CFG_BUSY), 32'd0);
      applyStimulus(1'b1, hunt[8], 1'b0);
      checkOutput("hunt", "busy_after_sync", 32'(CFG_BUSY), 32'd1);
      runFrame("hunt", 1'b1, 6'b011110, 1'b0, 0, 99, 1'b0, 4'b1101, 2'b01, 1'b1, 1'b0);

      // Asynchronous reset in the middle of LOAD.
      for (int b = 7; b >= 0; b--) applyStimulus(1'b1, syncWord[b], 1'b0);
      for (int j = 0; j < 3; j++) applyStimulus(1'b1, 1'b1, 1'b0);
      @(negedge IOCLK);
      CFG_VALID = 1'b0;
      #2;
      RSTN = 1'b0;
      #1;
      checkOutput("async_rst", "tsmux", 32'(TSMUX_OUT), 32'd0);
      checkOutput("async_rst", "dorreg", 32'(DORREG_OUT), 32'd0);
      checkOutput("async_rst", "busy", 32'(CFG_BUSY), 32'd0);
      checkOutput("async_rst", "ready", 32'(CFG_READY), 32'd1);
      @(negedge IOCLK);
      RSTN = 1'b1;
      runFrame("after_rst", 1'b0, 6'b110001, 1'b1, 0, 99, 1'b0, 4'b0110, 2'b10, 1'b1, 1'b0);
      modelTs  = 4'b0110;
      modelDor = 2'b10;

      // Randomized frames against the reference model.
      for (int r = 0; r < 40; r++) begin
         p             = 6'($urandom);
         bad           = ($urandom_range(0, 3) == 0);
         par           = evenParity(p) ^ bad;
         gap           = int'($urandom_range(0, 2));
         abortAfter    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 5)) : 99;
         abortInCommit = bit'($urandom_range(0, 1));
         if (abortAfter != 99) begin
            runFrame($sformatf("rnd%0d", r), 1'b0, p, par, gap, abortAfter, abortInCommit,
                     modelTs, modelDor, 1'b0, 1'b0);
         end else if (bad) begin
            runFrame($sformatf("rnd%0d", r), 1'b0, p, par, gap, abortAfter, abortInCommit,
                     modelTs, modelDor, 1'b0, 1'b1);
         end else begin
            modelIo(p, ts, dor);
            modelTs  = ts;
            modelDor = dor;
            runFrame($sformatf("rnd%0d", r), 1'b0, p, par, gap, abortAfter, abortInCommit,
                     modelTs, modelDor, 1'b1, 1'b0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
